// File: rtl/chrono_div_seq.sv
// rtl/chrono_div_seq.sv - seconds to MM:SS BCD converter driving a memory-mapped divider
// Define DIV_TIMEOUT_EN to abort a division after TIMEOUT unsuccessful done-polls.
module chrono_div_seq #(
  parameter int TIMEOUT  = 255,
  parameter int INIT_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] secs_in,
  output logic        busy,
  output logic        valid,
  output logic        sat,
  output logic        err,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_units,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic [4:0]  addr,
  output logic [15:0] periph_wdata,
  input  logic [31:0] periph_rdata
);

  localparam logic [4:0]  ADDR_A    = 5'h04;
  localparam logic [4:0]  ADDR_B    = 5'h08;
  localparam logic [4:0]  ADDR_INIT = 5'h0C;
  localparam logic [4:0]  ADDR_RES  = 5'h10;
  localparam logic [4:0]  ADDR_DONE = 5'h14;
  localparam logic [15:0] MAX_SECS  = 16'd5999;
  localparam logic [7:0]  GAP_LAST  = 8'(INIT_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_A, S_WR_B, S_INIT_HI, S_INIT_LO, S_GAP,
    S_POLL, S_POLL_CHK, S_RD, S_RD_CHK, S_DONE
  } state_t;

  typedef struct packed {
    logic        cs;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [15:0] data;
  } bus_t;

  function automatic bus_t bus_write(input logic [4:0] a, input logic [15:0] d);
    bus_t b;
    b = '{cs: 1'b1, rd: 1'b0, wr: 1'b1, addr: a, data: d};
    return b;
  endfunction

  function automatic bus_t bus_read(input logic [4:0] a);
    bus_t b;
    b = '{cs: 1'b1, rd: 1'b1, wr: 1'b0, addr: a, data: 16'd0};
    return b;
  endfunction

  state_t      state;
  bus_t        bus_q;
  logic [1:0]  op;
  logic [7:0]  gap_cnt;
  logic [5:0]  rem_s;
  logic [3:0]  min_t_q;
  logic [3:0]  min_u_q;
  logic [15:0] secs_clamped;

  assign secs_clamped = (secs_in > MAX_SECS) ? MAX_SECS : secs_in;

  // Bus strobes are registered so each access occupies exactly the cycle of its state.
  assign cs           = bus_q.cs;
  assign rd           = bus_q.rd;
  assign wr           = bus_q.wr;
  assign addr         = bus_q.addr;
  assign periph_wdata = bus_q.data;

`ifdef DIV_TIMEOUT_EN
  localparam logic [15:0] MISS_LAST = 16'(TIMEOUT - 1);
  logic        err_q;
  logic [15:0] miss_cnt;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Upper result bits are never needed: quotients and remainders stay below 100.
  logic unused_bits;
  assign unused_bits = ^{periph_rdata[31:22], 32'(TIMEOUT)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bus_q     <= '0;
      op        <= 2'd0;
      gap_cnt   <= 8'd0;
      rem_s     <= 6'd0;
      min_t_q   <= 4'd0;
      min_u_q   <= 4'd0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      sat       <= 1'b0;
      min_tens  <= 4'd0;
      min_units <= 4'd0;
      sec_tens  <= 4'd0;
      sec_units <= 4'd0;
`ifdef DIV_TIMEOUT_EN
      err_q     <= 1'b0;
      miss_cnt  <= 16'd0;
`endif
    end else begin
      bus_q <= '0;
      valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            sat   <= (secs_in > MAX_SECS);
            op    <= 2'd0;
`ifdef DIV_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            bus_q <= bus_write(ADDR_A, secs_clamped);
            state <= S_WR_A;
          end
        end
        S_WR_A: begin
          bus_q <= bus_write(ADDR_B, (op == 2'd0) ? 16'd60 : 16'd10);
          state <= S_WR_B;
        end
        S_WR_B: begin
          bus_q <= bus_write(ADDR_INIT, 16'd1);
          state <= S_INIT_HI;
        end
        S_INIT_HI: begin
          bus_q <= bus_write(ADDR_INIT, 16'd0);
          state <= S_INIT_LO;
        end
        S_INIT_LO: begin
          gap_cnt <= 8'd0;
`ifdef DIV_TIMEOUT_EN
          miss_cnt <= 16'd0;
`endif
          if (INIT_GAP == 0) begin
            bus_q <= bus_read(ADDR_DONE);
            state <= S_POLL;
          end else begin
            state <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus_q <= bus_read(ADDR_DONE);
            state <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        S_POLL: state <= S_POLL_CHK;
        S_POLL_CHK: begin
          if (periph_rdata[0]) begin
            bus_q <= bus_read(ADDR_RES);
            state <= S_RD;
          end else begin
`ifdef DIV_TIMEOUT_EN
            if (miss_cnt == MISS_LAST) begin
              err_q <= 1'b1;
              valid <= 1'b1;
              state <= S_DONE;
            end else begin
              miss_cnt <= miss_cnt + 16'd1;
              bus_q    <= bus_read(ADDR_DONE);
              state    <= S_POLL;
            end
`else
            bus_q <= bus_read(ADDR_DONE);
            state <= S_POLL;
`endif
          end
        end
        S_RD: state <= S_RD_CHK;
        S_RD_CHK: begin
          case (op)
            2'd0: begin
              rem_s <= periph_rdata[21:16];
              op    <= 2'd1;
              bus_q <= bus_write(ADDR_A, periph_rdata[15:0]);
              state <= S_WR_A;
            end
            2'd1: begin
              min_t_q <= periph_rdata[3:0];
              min_u_q <= periph_rdata[19:16];
              op      <= 2'd2;
              bus_q   <= bus_write(ADDR_A, {10'd0, rem_s});
              state   <= S_WR_A;
            end
            default: begin
              // All four digits land together with the valid pulse.
              min_tens  <= min_t_q;
              min_units <= min_u_q;
              sec_tens  <= periph_rdata[3:0];
              sec_units <= periph_rdata[19:16];
              valid     <= 1'b1;
              state     <= S_DONE;
            end
          endcase
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chrono_div_seq.sv
// tb/tb_chrono_div_seq.sv - self-checking bench for chrono_div_seq with a behavioural divider
`timescale 1ns/1ps
module tb_chrono_div_seq;

  localparam int GAP = 2;
`ifdef DIV_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] secs_in = 16'd0;
  logic        busy, valid, sat, err, cs, rd, wr;
  logic [3:0]  min_tens, min_units, sec_tens, sec_units;
  logic [4:0]  addr;
  logic [15:0] periph_wdata;
  logic [31:0] periph_rdata;

  chrono_div_seq #(.TIMEOUT(TMO), .INIT_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .secs_in(secs_in),
    .busy(busy), .valid(valid), .sat(sat), .err(err),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens), .sec_units(sec_units),
    .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .periph_wdata(periph_wdata), .periph_rdata(periph_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider peripheral: done rises m_lat cycles after init, d_out is registered.
  logic [15:0] m_a, m_b;
  logic [31:0] m_dout;
  logic        m_done;
  int          m_cnt;
  int          m_lat = 5;
  bit          m_never = 1'b0;
  assign periph_rdata = m_dout;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_a <= 16'd0; m_b <= 16'd0; m_cnt <= 0; m_done <= 1'b0; m_dout <= 32'd0;
    end else begin
      if (cs && wr && addr == 5'h04) m_a <= periph_wdata;
      if (cs && wr && addr == 5'h08) m_b <= periph_wdata;
      if (cs && wr && addr == 5'h0C && periph_wdata[0]) begin
        m_cnt <= m_lat; m_done <= 1'b0;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !m_never) m_done <= 1'b1;
      end
      if (cs && rd)
        m_dout <= (addr == 5'h14) ? {31'd0, m_done} :
                  (addr == 5'h10) ? {m_a % m_b, m_a / m_b} : 32'd0;
    end
  end

  typedef struct packed { logic wr; logic [4:0] addr; logic [15:0] data; } acc_t;
  acc_t bus_log[$];
  int   bus_viol = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (cs) begin
        if (rd == wr) bus_viol++;
        bus_log.push_back({wr, addr, wr ? periph_wdata : 16'd0});
      end else if (rd || wr || addr != 5'd0 || periph_wdata != 16'd0) begin
        bus_viol++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [15:0] cur_digits();
    return {min_tens, min_units, sec_tens, sec_units};
  endfunction

  function automatic logic [15:0] ref_digits(input int secs);
    int c, m, s;
    c = (secs > 5999) ? 5999 : secs;
    m = c / 60;
    s = c % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Done is visible lat+1 cycles after the init write; polls start 2+GAP cycles after it, every 2 cycles.
  function automatic int polls_for(input int lat);
    int slack;
    slack = lat + 1 - (2 + GAP);
    return (slack <= 0) ? 1 : (slack + 1) / 2 + 1;
  endfunction

  logic [15:0] last_digits = 16'd0;

  task automatic run_conv(input string tag, input int secs, input int lat,
                          input logic [15:0] exp_dig, input bit exp_sat, input bit glitch);
    int base, viol0, c0, n, p, mism, len;
    int av[3];
    int bv[3];
    logic [15:0] prev;
    acc_t e;
    acc_t exp_q[$];
    m_lat = lat;
    base = bus_log.size();
    viol0 = bus_viol;
    start = 1'b1; secs_in = 16'(secs); c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    prev = cur_digits();
    while (!valid && n < 3000) begin
      prev = cur_digits();
      if (glitch && n == 10) begin start = 1'b1; secs_in = 16'd4321; end
      if (glitch && n == 11) start = 1'b0;
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      chk({tag, "_valid_timeout"}, 0, 1);
      return;
    end
    p = polls_for(lat);
    chk({tag, "_latency"}, cyc - c0 + 1, 3 * (4 + GAP + 2 * p + 2) + 2);
    chk({tag, "_digits"}, cur_digits(), exp_dig);
    chk({tag, "_pre_hold"}, prev, last_digits);
    chk({tag, "_sat"}, sat, exp_sat);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy_at_valid"}, busy, 1);
    @(negedge clk);
    chk({tag, "_valid_busy_end"}, {valid, busy}, 0);
    av[0] = (secs > 5999) ? 5999 : secs;
    av[1] = av[0] / 60;
    av[2] = av[0] % 60;
    bv[0] = 60; bv[1] = 10; bv[2] = 10;
    for (int op = 0; op < 3; op++) begin
      e = {1'b1, 5'h04, 16'(av[op])}; exp_q.push_back(e);
      e = {1'b1, 5'h08, 16'(bv[op])}; exp_q.push_back(e);
      e = {1'b1, 5'h0C, 16'd1};       exp_q.push_back(e);
      e = {1'b1, 5'h0C, 16'd0};       exp_q.push_back(e);
      for (int k = 0; k < p; k++) begin
        e = {1'b0, 5'h14, 16'd0}; exp_q.push_back(e);
      end
      e = {1'b0, 5'h10, 16'd0}; exp_q.push_back(e);
    end
    len = bus_log.size() - base;
    chk({tag, "_bus_len"}, len, exp_q.size());
    mism = 0;
    for (int i = 0; i < len && i < exp_q.size(); i++)
      if (bus_log[base + i] !== exp_q[i]) mism++;
    chk({tag, "_bus_order"}, mism, 0);
    chk({tag, "_bus_rules"}, bus_viol - viol0, 0);
    last_digits = exp_dig;
  endtask

  typedef struct { int secs; int lat; logic [15:0] dig; bit sat; } vec_t;

  initial begin
    vec_t vecs[9];
    int   secs, lat, n;
    bit   found;
    vecs[0] = '{3725,  5, 16'h6205, 1'b0};
    vecs[1] = '{0,     1, 16'h0000, 1'b0};
    vecs[2] = '{5999,  3, 16'h9959, 1'b0};
    vecs[3] = '{7000,  2, 16'h9959, 1'b1};
    vecs[4] = '{65535, 7, 16'h9959, 1'b1};
    vecs[5] = '{6000,  4, 16'h9959, 1'b1};
    vecs[6] = '{59,    6, 16'h0059, 1'b0};
    vecs[7] = '{60,    2, 16'h0100, 1'b0};
    vecs[8] = '{600,   8, 16'h1000, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy, valid, sat, err, cs, rd, wr, addr, periph_wdata, cur_digits()}, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_conv($sformatf("vec%0d", i), vecs[i].secs, vecs[i].lat, vecs[i].dig, vecs[i].sat, 1'b0);

    run_conv("busy_start", 1234, 6, 16'h2034, 1'b0, 1'b1);

`ifdef DIV_TIMEOUT_EN
    begin
      int base, polls;
      base = bus_log.size();
      polls = 0;
      m_never = 1'b1;
      start = 1'b1; secs_in = 16'd1500;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!valid && n < 3000) begin @(negedge clk); n++; end
      chk("tmo_valid", valid, 1);
      chk("tmo_err", err, 1);
      chk("tmo_digits", cur_digits(), last_digits);
      for (int i = base; i < bus_log.size(); i++)
        if (!bus_log[i].wr && bus_log[i].addr == 5'h14) polls++;
      chk("tmo_polls", polls, TMO);
      @(negedge clk);
      chk("tmo_pulse_end", {valid, busy}, 0);
      m_never = 1'b0;
    end
`endif

    run_conv("pre_reset", 3725, 5, 16'h6205, 1'b0, 1'b0);
    m_lat = 20;
    start = 1'b1; secs_in = 16'd7000;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      n++;
      if (cs && rd && addr == 5'h14) found = 1'b1;
    end
    chk("reach_poll", found, 1);
    reset = 1'b0;
    #1;
    chk("rst_bus_idle", {cs, rd, wr, addr, periph_wdata}, 0);
    chk("rst_outputs", {busy, valid, sat, err, cur_digits()}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_digits = 16'd0;
    @(negedge clk);
    run_conv("after_reset", 3725, 5, 16'h6205, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      secs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6000, 65535)) : int'($urandom_range(0, 5999));
      lat = $urandom_range(1, 9);
      run_conv($sformatf("rand%0d", i), secs, lat, ref_digits(secs), secs > 5999, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chrono_div_seq.md
# chrono_div_seq

Bus-master sequencer sitting directly upstream of the chronometer's memory-mapped divider peripheral. On `start` it converts a 16-bit elapsed-seconds count into four BCD display digits (MM:SS) by issuing three divisions through the peripheral's `cs/addr/rd/wr` register interface. For each division it writes the operands, pulses init, polls done and reads the result. The digits it produces feed the display driver.

## Interface
- `TIMEOUT`, default 255: maximum done-polls per division before abort (used only with `DIV_TIMEOUT_EN`).
- `INIT_GAP`, default 2: idle cycles between init deassert and the first done-poll.
- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset); one clock.
- `start` in 1: begin conversion; sampled only in IDLE.
- `secs_in` in 16: elapsed seconds; captured on accepted `start`.
- `busy` out 1: high from the cycle after `start` is accepted until the end of DONE.
- `valid` out 1: one-cycle pulse when digits update.
- `sat` out 1: captured `secs_in` was above 5999 and was clamped.
- `err` out 1: last conversion aborted on timeout.
- `min_tens`, `min_units`, `sec_tens`, `sec_units` out 4 each: BCD digits, held between conversions.
- `cs`, `rd`, `wr` out 1 each: peripheral bus strobes.
- `addr` out 5: peripheral register address.
- `periph_wdata` out 16: drives the peripheral `d_in`.
- `periph_rdata` in 32: the peripheral's registered `d_out`.

## Operation
- Register map: 0x04 = A, 0x08 = B, 0x0C = init (bit 0), 0x10 = result, 0x14 = done (bit 0).
- Result format: `result[15:0]` is the quotient; `result[31:16]` is the remainder.
- Capture: on accepted `start`, latch `secs_in`.
  - If the value is above 5999, load 5999 and set `sat`; otherwise clear `sat`.
  - Always clear `err`.
- Division sequence:
  - op0: A = captured seconds, B = 60. Quotient is minutes (m), remainder is seconds (s).
  - op1: A = m, B = 10. Quotient is `min_tens`, remainder is `min_units`.
  - op2: A = s, B = 10. Quotient is `sec_tens`, remainder is `sec_units`.
- States and transitions:
  - IDLE → WR_A (write A) → WR_B (write B) → INIT_HI (write 0x0C, data 1) → INIT_LO (write 0x0C, data 0) → GAP.
  - GAP waits `INIT_GAP` cycles, then → POLL.
  - POLL issues a read of 0x14, then → POLL_CHK.
  - POLL_CHK: if `periph_rdata[0]` = 1 → RD; else → POLL.
  - RD issues a read of 0x10, then → RD_CHK.
  - RD_CHK stores the quotient and remainder. If op2 is finished → DONE; otherwise advance the op index and → WR_A.
  - DONE: load all four digit outputs simultaneously, pulse `valid`, → IDLE.
- Bus rules:
  - Every access is exactly one cycle with `cs` = 1 and exactly one of `rd`/`wr` high.
  - In all other states `cs`, `rd`, `wr` = 0, `addr` = 0 and `periph_wdata` = 0.
  - `periph_rdata` is sampled only in the cycle after a read access (`*_CHK`).
- Widths: only quotient bits [3:0] are used for digits; the clamp guarantees they are at most 9.
- `start` while busy: ignored, with no queueing.
- Reset mid-operation:
  - The bus goes idle immediately (asynchronous).
  - FSM returns to IDLE.
  - Digits, `sat` and `err` reset to 0.

## Timing
- Reset values: `busy`, `valid`, `sat`, `err`, `cs`, `rd`, `wr` = 0; `addr`, `periph_wdata` = 0; all digits = 0.
- Per-division latency is 4 + `INIT_GAP` + 2·P + 2 cycles, where P is the number of polls (P ≥ 1).
- Total latency from `start` to `valid` is the sum of the three divisions plus 2 cycles (capture and DONE).
- `valid` rises in the same cycle the digits change. `busy` falls on the cycle after `valid`.
- Back-to-back conversions: `start` is accepted in the first IDLE cycle after DONE.

## Configuration
- Macro: `DIV_TIMEOUT_EN`.
- Defined:
  - A poll counter counts POLL_CHK misses per division.
  - On the `TIMEOUT`-th miss the FSM goes to DONE with `err` = 1 and `valid` pulsed.
  - Digit outputs keep their previous values.
- Undefined:
  - No counter is built; polling continues indefinitely.
  - `err` is tied to 0.

## Test plan
- `secs_in` = 3725, with a divider model that has 5-cycle latency → `valid` pulse with digits 6,2,0,5; `sat` = 0, `err` = 0. Check bus writes in order: 0x04 = 3725, 0x08 = 60, 0x0C = 1, 0x0C = 0.
- `secs_in` = 0 → digits 0,0,0,0; `valid` pulse; three complete bus sequences are observed.
- `secs_in` = 5999 → digits 9,9,5,9 with `sat` = 0. `secs_in` = 7000 → digits 9,9,5,9 with `sat` = 1.
- `DIV_TIMEOUT_EN` with `TIMEOUT` = 4 and a model that never asserts done → exactly 4 reads of 0x14, then `err` = 1 and `valid` pulse with digits unchanged.
- `start` re-asserted during `busy` → ignored, and digits reflect only the first `secs_in`. Reset asserted in POLL → `cs` = 0 immediately and all outputs 0. The next `start` completes normally.
